scp_cmd_scheduler: RTL

//  Shares the single green/yellow/red command port of the SCP-079 sequencer among N_REQ

---
 rtl/scp_pkg.sv | 57 +++++
 rtl/rr_arbiter.sv | 38 +++
 rtl/scp_cmd_scheduler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/scp_pkg.sv
// Shared encodings for the SCP-079 command scheduler: command codes, sequencer
// state codes, scheduler FSM states, counter widths and the legality rule.
package scp_pkg;

    localparam int unsigned CMD_W      = 2;
    localparam int unsigned SEQ_W      = 3;
    localparam int unsigned HOLD_CNT_W = 4;
    localparam int unsigned LOCK_CNT_W = 6;
    localparam int unsigned RED_CNT_W  = 8;

    typedef enum logic [CMD_W-1:0] {
        CMD_NONE   = 2'b00,
        CMD_GREEN  = 2'b01,
        CMD_YELLOW = 2'b10,
        CMD_RED    = 2'b11
    } cmd_e;

    typedef enum logic [SEQ_W-1:0] {
        SEQ_LAYLOW  = 3'b000,
        SEQ_CHEAT   = 3'b001,
        SEQ_ATK_SEC = 3'b010,
        SEQ_ATK_DB  = 3'b011,
        SEQ_FAIL    = 3'b100,
        SEQ_CONNECT = 3'b101
    } seq_state_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } fsm_state_e;

    // Whether a command may be issued while the sequencer is in state st.
    function automatic logic cmd_legal(input cmd_e cmd, input logic [SEQ_W-1:0] st);
        logic ok;
        ok = 1'b0;
        case (cmd)
            CMD_GREEN, CMD_RED: ok = !(st inside {SEQ_CHEAT, SEQ_FAIL, SEQ_CONNECT});
            CMD_YELLOW:         ok = !(st inside {SEQ_LAYLOW, SEQ_CHEAT, SEQ_FAIL, SEQ_CONNECT});
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Command to {green, yellow, red} line pattern.
    function automatic logic [2:0] cmd_lines(input cmd_e cmd);
        logic [2:0] lines;
        lines = 3'b000;
        case (cmd)
            CMD_GREEN:  lines = 3'b100;
            CMD_YELLOW: lines = 3'b010;
            CMD_RED:    lines = 3'b001;
            default:    lines = 3'b000;
        endcase
        return lines;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: returns the first requesting index at or after ptr.
//   req       in   N       request vector
//   ptr       in   PTR_W   index with highest priority this cycle
//   gnt_c     out  N       one-hot winner (zero when nothing requests)
//   gnt_idx_c out  PTR_W   binary index of the winner
//   any_c     out  1       at least one request present
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt_c,
    output logic [PTR_W-1:0] gnt_idx_c,
    output logic             any_c
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // Scan N positions starting at ptr, wrapping modulo N.
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PTR_W'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt_c[idx] = 1'b1;
                gnt_idx_c  = idx;
            end
        end
        any_c = found;
    end

endmodule

// File: rtl/scp_cmd_scheduler.sv
// Shares the single green/yellow/red command port of the SCP-079 sequencer among
// N_REQ requesters: class priority (red > yellow > green), round-robin within a
// class, legality filtering against seq_state, HOLD_CYCLES-wide command pulses and
// a red lockout window.
//   clock, reset        clock; asynchronous active-high reset
//   req_valid/req_cmd   per-requester pending flag and 2-bit command
//   seq_state           current sequencer state
//   grant, cmd_reject   one-cycle consume pulse (reject when filtered out)
//   green/yellow/red    command lines, one-hot or idle
//   busy                command being held
//   red_count           reds issued, saturating
module scp_cmd_scheduler
    import scp_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned RED_LOCKOUT = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [2*N_REQ-1:0]     req_cmd,
    input  logic [2:0]             seq_state,
    output logic [N_REQ-1:0]       grant,
    output logic                   cmd_reject,
    output logic                   green,
    output logic                   yellow,
    output logic                   red,
    output logic                   busy,
    output logic [7:0]             red_count
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || HOLD_CYCLES < 1 || HOLD_CYCLES > 15 || RED_LOCKOUT > 63) begin : g_param_err
        $error("scp_cmd_scheduler: parameter out of range");
    end

    fsm_state_e            state_q, state_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic                  reject_q, reject_d;
    logic [2:0]            lines_q, lines_d;      // {green, yellow, red}
    logic                  busy_q, busy_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [LOCK_CNT_W-1:0] lockout_q, lockout_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [RED_CNT_W-1:0]  red_count_q, red_count_d;

    logic [N_REQ-1:0]      red_vec_c, yellow_vec_c, green_vec_c, none_vec_c;
    logic [N_REQ-1:0]      arb_req_c, arb_gnt_c;
    logic [PTR_W-1:0]      arb_idx_c;
    logic                  arb_any_c;
    cmd_e                  win_cmd_c;
    logic                  win_legal_c;

    // Split live requests by class. The requester granted last cycle may still be
    // presenting valid while it sees the grant, so it is masked for one cycle.
    always_comb begin
        red_vec_c    = '0;
        yellow_vec_c = '0;
        green_vec_c  = '0;
        none_vec_c   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && !grant_q[i]) begin
                case (cmd_e'(req_cmd[2*i +: 2]))
                    CMD_RED:    red_vec_c[i]    = 1'b1;
                    CMD_YELLOW: yellow_vec_c[i] = 1'b1;
                    CMD_GREEN:  green_vec_c[i]  = 1'b1;
                    default:    none_vec_c[i]   = 1'b1;
                endcase
            end
        end
    end

    // Class priority; reds wait (not rejected) while the lockout runs. Valid
    // requests carrying no command are flushed at the lowest priority.
    always_comb begin
        arb_req_c = none_vec_c;
        win_cmd_c = CMD_NONE;
        if (lockout_q == '0 && |red_vec_c) begin
            arb_req_c = red_vec_c;
            win_cmd_c = CMD_RED;
        end else if (|yellow_vec_c) begin
            arb_req_c = yellow_vec_c;
            win_cmd_c = CMD_YELLOW;
        end else if (|green_vec_c) begin
            arb_req_c = green_vec_c;
            win_cmd_c = CMD_GREEN;
        end
        win_legal_c = cmd_legal(win_cmd_c, seq_state);
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .req       (arb_req_c),
        .ptr       (ptr_q),
        .gnt_c     (arb_gnt_c),
        .gnt_idx_c (arb_idx_c),
        .any_c     (arb_any_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = '0;
        reject_d    = 1'b0;
        lines_d     = lines_q;
        busy_d      = busy_q;
        hold_cnt_d  = hold_cnt_q;
        ptr_d       = ptr_q;
        red_count_d = red_count_q;
        lockout_d   = (lockout_q != '0) ? lockout_q - LOCK_CNT_W'(1) : lockout_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_any_c) begin
                    grant_d = arb_gnt_c;
                    ptr_d   = (arb_idx_c == PTR_W'(N_REQ - 1)) ? '0 : arb_idx_c + PTR_W'(1);
                    if (win_legal_c) begin
                        lines_d    = cmd_lines(win_cmd_c);
                        busy_d     = 1'b1;
                        hold_cnt_d = HOLD_CNT_W'(HOLD_CYCLES - 1);
                        state_d    = ST_HOLD;
                        if (win_cmd_c == CMD_RED && red_count_q != '1) begin
                            red_count_d = red_count_q + RED_CNT_W'(1);
                        end
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = ST_IDLE;
                    lines_d = 3'b000;
                    busy_d  = 1'b0;
                    // Lockout starts as the red line falls.
                    if (lines_q[0]) begin
                        lockout_d = LOCK_CNT_W'(RED_LOCKOUT);
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            reject_q    <= 1'b0;
            lines_q     <= 3'b000;
            busy_q      <= 1'b0;
            hold_cnt_q  <= '0;
            lockout_q   <= '0;
            ptr_q       <= '0;
            red_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            reject_q    <= reject_d;
            lines_q     <= lines_d;
            busy_q      <= busy_d;
            hold_cnt_q  <= hold_cnt_d;
            lockout_q   <= lockout_d;
            ptr_q       <= ptr_d;
            red_count_q <= red_count_d;
        end
    end

    assign grant      = grant_q;
    assign cmd_reject = reject_q;
    assign green      = lines_q[2];
    assign yellow     = lines_q[1];
    assign red        = lines_q[0];
    assign busy       = busy_q;
    assign red_count  = red_count_q;

endmodule
